// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
//
// Takes the ex_mem_* bundle from the execute stage. Loads and stores go out
// over a request/acknowledge data-memory port. The stage registers the
// mem_wb_* write-back bundle. Upstream is stalled for as long as an access is
// outstanding. A bounded wait counter aborts accesses that are never
// acknowledged.
//
// Parameters:
//   MAX_WAIT    maximum BUSY cycles per access before abort (2..255)
// Ports:
//   clock, reset          single clock; synchronous active-low reset
//   ex_mem_*              instruction bundle from execute (held while mem_stall)
//   mem_req/rw/addr/wdata registered request to data memory
//   mem_ack, mem_rdata    completion strobe and load data from data memory
//   mem_stall             high while an access is outstanding (state == BUSY)
//   mem_error             one-cycle pulse when an access is aborted on timeout
//   mem_wb_*              registered write-back bundle
//
// Memory handshake: mem_req rises on the edge that accepts a load or store.
// While mem_req is high, mem_rw, mem_addr and mem_wdata are held stable.
// The access completes on the first rising edge at which mem_ack is sampled
// high; mem_rdata must be valid in that same cycle. mem_req drops on that
// edge. mem_ack is ignored whenever no request is outstanding.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_mem_readmem,
    input  logic        ex_mem_writemem,
    input  logic [31:0] ex_mem_regb,
    input  logic        ex_mem_selwsource,
    input  logic [4:0]  ex_mem_regdest,
    input  logic        ex_mem_writereg,
    input  logic [31:0] ex_mem_wbvalue,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_stall,
    output logic        mem_error,
    output logic [4:0]  mem_wb_regdest,
    output logic        mem_wb_writereg,
    output logic [31:0] mem_wb_wbvalue
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state, state_next;
    logic [7:0]  wait_cnt, wait_cnt_d;

    // Fields of the in-flight instruction, captured when the access starts.
    logic [4:0]  lat_regdest, lat_regdest_d;
    logic        lat_writereg, lat_writereg_d;
    logic        lat_selw, lat_selw_d;
    logic [31:0] lat_alu, lat_alu_d;

    logic        mem_req_d, mem_rw_d, mem_error_d;
    logic [31:0] mem_addr_d, mem_wdata_d;
    logic [4:0]  mem_wb_regdest_d;
    logic        mem_wb_writereg_d;
    logic [31:0] mem_wb_wbvalue_d;

    logic mem_op;
    logic timeout;

    assign mem_op  = ex_mem_readmem | ex_mem_writemem;
    // Ack wins over timeout: timeout only fires when no ack is present.
    assign timeout = (state == BUSY) && !mem_ack && (wait_cnt == LAST_WAIT);

    // Stall comes straight from the state register, never from inputs.
    assign mem_stall = (state == BUSY);

    // State register plus all registered datapath.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            lat_regdest     <= '0;
            lat_writereg    <= 1'b0;
            lat_selw        <= 1'b0;
            lat_alu         <= '0;
            mem_req         <= 1'b0;
            mem_rw          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_error       <= 1'b0;
            mem_wb_regdest  <= '0;
            mem_wb_writereg <= 1'b0;
            mem_wb_wbvalue  <= '0;
        end else begin
            state           <= state_next;
            wait_cnt        <= wait_cnt_d;
            lat_regdest     <= lat_regdest_d;
            lat_writereg    <= lat_writereg_d;
            lat_selw        <= lat_selw_d;
            lat_alu         <= lat_alu_d;
            mem_req         <= mem_req_d;
            mem_rw          <= mem_rw_d;
            mem_addr        <= mem_addr_d;
            mem_wdata       <= mem_wdata_d;
            mem_error       <= mem_error_d;
            mem_wb_regdest  <= mem_wb_regdest_d;
            mem_wb_writereg <= mem_wb_writereg_d;
            mem_wb_wbvalue  <= mem_wb_wbvalue_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (mem_op) state_next = BUSY;
            BUSY:    if (mem_ack || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs and holding registers.
    always_comb begin
        wait_cnt_d        = wait_cnt;
        lat_regdest_d     = lat_regdest;
        lat_writereg_d    = lat_writereg;
        lat_selw_d        = lat_selw;
        lat_alu_d         = lat_alu;
        mem_req_d         = mem_req;
        mem_rw_d          = mem_rw;
        mem_addr_d        = mem_addr;
        mem_wdata_d       = mem_wdata;
        mem_error_d       = 1'b0;
        mem_wb_regdest_d  = mem_wb_regdest;
        mem_wb_writereg_d = mem_wb_writereg;
        mem_wb_wbvalue_d  = mem_wb_wbvalue;

        unique case (state)
            IDLE: begin
                if (!mem_op) begin
                    // Plain ALU instruction: one-cycle pass-through.
                    mem_wb_regdest_d  = ex_mem_regdest;
                    mem_wb_writereg_d = ex_mem_writereg;
                    mem_wb_wbvalue_d  = ex_mem_wbvalue;
                end else begin
                    lat_regdest_d     = ex_mem_regdest;
                    lat_writereg_d    = ex_mem_writereg;
                    lat_selw_d        = ex_mem_selwsource;
                    lat_alu_d         = ex_mem_wbvalue;
                    mem_addr_d        = ex_mem_wbvalue;
                    mem_wdata_d       = ex_mem_regb;
                    // A load flag takes precedence over a simultaneous store flag.
                    mem_rw_d          = ex_mem_writemem & ~ex_mem_readmem;
                    mem_req_d         = 1'b1;
                    wait_cnt_d        = '0;
                    mem_wb_writereg_d = 1'b0;
                end
            end
            BUSY: begin
                mem_wb_writereg_d = 1'b0;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_rw) begin
                        mem_wb_regdest_d  = lat_regdest;
                        mem_wb_writereg_d = lat_writereg;
                        mem_wb_wbvalue_d  = lat_selw ? mem_rdata : lat_alu;
                    end
                end else if (timeout) begin
                    mem_req_d   = 1'b0;
                    mem_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt + 8'd1;
                end
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and write-back. Consumes the execute stage's `ex_mem_*` bundle, performs loads and stores over a request/acknowledge data-memory port, and registers the write-back bundle `mem_wb_*`. It stalls upstream for the whole duration of an access. A bounded wait counter aborts accesses the memory never acknowledges.

## Interface
- `MAX_WAIT`, default 16: maximum number of BUSY cycles before an unacknowledged access is aborted; legal range 2–255.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low; sampled on the rising edge of `clock`.
- `ex_mem_readmem` input 1: the instruction is a load.
- `ex_mem_writemem` input 1: the instruction is a store.
- `ex_mem_regb` input 32: store data.
- `ex_mem_selwsource` input 1: write-back source select; 1 selects memory data, 0 selects `ex_mem_wbvalue`.
- `ex_mem_regdest` input 5: destination register.
- `ex_mem_writereg` input 1: register-file write enable.
- `ex_mem_wbvalue` input 32: ALU/shifter result; also the memory address for loads and stores.
- `mem_ack` input 1: memory has completed the pending request; `mem_rdata` is valid when this is high.
- `mem_rdata` input 32: load data.
- `mem_req` output 1: access request.
- `mem_rw` output 1: 1 = write, 0 = read.
- `mem_addr` output 32: access address.
- `mem_wdata` output 32: store data.
- `mem_stall` output 1: upstream must hold the `ex_mem_*` bundle.
- `mem_error` output 1: one-cycle pulse when an access is aborted on timeout.
- `mem_wb_regdest` output 5: registered destination register.
- `mem_wb_writereg` output 1: registered register-file write enable.
- `mem_wb_wbvalue` output 32: registered write-back value.

## Operation
- FSM with two states, IDLE and BUSY.
- Reset (`reset`==0 at an edge):
  - state goes to IDLE and the wait counter to 0.
  - All registered outputs go to 0: `mem_req`, `mem_rw`, `mem_addr`, `mem_wdata`, `mem_error`, and all `mem_wb_*`.
  - Reset overrides any pending access. `mem_req` is 0 after that edge, and no late `mem_ack` is honoured.
- IDLE, no memory op (`readmem`==0 and `writemem`==0):
  - `mem_wb_regdest`, `mem_wb_writereg` and `mem_wb_wbvalue` are loaded from the `ex_mem_*` fields.
  - `mem_wb_wbvalue` is always `ex_mem_wbvalue` here; `selwsource` is ignored.
- IDLE, memory op present:
  - Latch `regdest`, `writereg` and `selwsource`, plus the ALU value into an internal holding register.
  - Set `mem_addr` to `ex_mem_wbvalue` and `mem_wdata` to `ex_mem_regb`.
  - `mem_rw` is 1 for a store.
  - If `readmem` and `writemem` are both 1, the access is a read and `writemem` is ignored.
  - Set `mem_req` to 1, clear the counter, and go to BUSY.
  - `mem_wb_writereg` is 0 for this cycle (bubble).
- BUSY:
  - `ex_mem_*` inputs are ignored.
  - `mem_req`, `mem_rw`, `mem_addr` and `mem_wdata` are held constant.
  - `mem_wb_writereg` stays 0.
  - The counter increments every cycle without an ack.
- BUSY with `mem_ack`==1 (completion):
  - `mem_req` goes to 0 and the state returns to IDLE.
  - Read: `mem_wb_wbvalue` becomes `mem_rdata` if the latched `selwsource`==1, otherwise the held ALU value. `mem_wb_writereg` becomes the latched `writereg`. `mem_wb_regdest` becomes the latched `regdest`.
  - Write: `mem_wb_writereg` is 0.
- BUSY, no ack, and counter == `MAX_WAIT`-1 (timeout):
  - Abort the access: `mem_req` goes to 0, `mem_error` is 1 for one cycle, `mem_wb_writereg` is 0, and the state returns to IDLE.
- Ack has priority over timeout when both occur in the same cycle.
- `mem_ack` is ignored while in IDLE.
- `mem_error` is 0 in every cycle other than the abort cycle.

## Timing
- `mem_stall` is (state==BUSY). It is derived only from the state register, with no combinational path from the inputs.
- A non-memory instruction has a latency of 1 cycle from `ex_mem_*` to `mem_wb_*`.
- Memory op sampled at edge E0:
  - `mem_req` is high from E0.
  - If `mem_ack` is first high in the cycle before edge E0+k (k ≥ 1), the result appears at E0+k. `mem_stall` is high during cycles E0 to E0+k-1.
  - Minimum (zero-wait ack) is 2 edges from input to result.
- At most `MAX_WAIT` BUSY cycles per access.
- Upstream holds the next instruction during the stall. It is consumed at the first IDLE edge after completion, so back-to-back memory ops have no extra gap.

## Test plan
- Reset with all inputs nonzero -> every output is 0 and `mem_stall` is 0. Release reset, then drive an ALU op (`wbvalue`=0x1234, `regdest`=5, `writereg`=1) -> next edge shows `mem_wb_wbvalue`=0x1234, `mem_wb_regdest`=5, `mem_wb_writereg`=1.
- Load at 0x100 with `selwsource`=1, `regdest`=7; ack after 3 BUSY cycles with `rdata`=0xDEADBEEF:
  - `mem_req`=1, `mem_rw`=0, `mem_addr`=0x100, and `mem_stall` is high for 3 cycles.
  - Then `mem_wb_wbvalue`=0xDEADBEEF, `regdest`=7, `writereg`=1.
- Store at 0x200 with `regb`=0xCAFE; zero-wait ack:
  - `mem_rw`=1, `mem_wdata`=0xCAFE, and `mem_stall` is high for exactly 1 cycle.
  - `mem_wb_writereg` stays 0.
- Load with `MAX_WAIT`=4 and no ack -> `mem_req` is high for 4 cycles, then `mem_error` pulses once, `writereg` is 0, and the block returns to IDLE.
- Reset asserted during BUSY, with ack asserted in the following cycle -> `mem_req` is 0 after the reset edge and `mem_wb_*` stays 0.
- Two consecutive loads (addresses 0x10 and 0x14, each acked after 1 cycle) -> both results are written back in order. The second `mem_req` rises on the edge right after the first completes.
